// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue slice.
//   ALU ctrl encodings (ALU_AND..ALU_SLTU), MIPS opcode/funct values,
//   operand-extension selector and the decoder result struct.
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'd0;
    localparam logic [2:0] ALU_OR   = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_ADDU = 3'd4;
    localparam logic [2:0] ALU_SLL  = 3'd5;
    localparam logic [2:0] ALU_SUB  = 3'd6;
    localparam logic [2:0] ALU_SLTU = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        EXT_NONE = 2'd0,   // B = rt_val
        EXT_SIGN = 2'd1,   // B = sign-extended imm
        EXT_ZERO = 2'd2    // B = zero-extended imm
    } ext_sel_t;

    typedef struct packed {
        logic [2:0] ctrl;
        ext_sel_t   ext_sel;
        logic       swap_sll;  // A takes rt_val, shamt taken from instruction
        logic       ovf_chk;   // alu_ovf is meaningful for this op
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_op_issue_if.sv
// Bundle of the issue block's handshake and ALU buses.
//   upstream : in_valid/in_ready + instruction fields and operand values
//   ALU      : alu_ctrl/a/b/shamt out, alu_r and flags back
//   downstream: out_valid/out_ready + result, dst, wen and flags
// Modport slave is the issue block's view; master is the surrounding core's.
interface alu_op_issue_if #(
    parameter int W  = 32,
    parameter int RW = 5
);
    logic          in_valid, in_ready;
    logic [5:0]    opcode, funct;
    logic [4:0]    shamt_in;
    logic [15:0]   imm;
    logic [W-1:0]  rs_val, rt_val;
    logic [RW-1:0] dst;

    logic [2:0]    alu_ctrl;
    logic [W-1:0]  alu_a, alu_b;
    logic [4:0]    alu_shamt;
    logic [W-1:0]  alu_r;
    logic          alu_cout, alu_ovf, alu_ze;

    logic          out_valid, out_ready;
    logic [W-1:0]  out_r;
    logic [RW-1:0] out_dst;
    logic          out_wen, out_ze, out_cout, out_illegal, out_trap;

    modport slave (
        input  in_valid, opcode, funct, shamt_in, imm, rs_val, rt_val, dst,
        output in_ready,
        output alu_ctrl, alu_a, alu_b, alu_shamt,
        input  alu_r, alu_cout, alu_ovf, alu_ze,
        output out_valid, out_r, out_dst, out_wen, out_ze, out_cout, out_illegal, out_trap,
        input  out_ready
    );

    modport master (
        output in_valid, opcode, funct, shamt_in, imm, rs_val, rt_val, dst,
        input  in_ready,
        input  alu_ctrl, alu_a, alu_b, alu_shamt,
        output alu_r, alu_cout, alu_ovf, alu_ze,
        input  out_valid, out_r, out_dst, out_wen, out_ze, out_cout, out_illegal, out_trap,
        output out_ready
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational MIPS opcode/funct decode into the ALU ctrl code plus
// operand-selection and checking attributes.
//   opcode, funct : instruction fields
//   dec           : {ctrl, ext_sel, swap_sll, ovf_chk, illegal}
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);
    always_comb begin
        dec = '{ctrl: ALU_AND, ext_sel: EXT_NONE, swap_sll: 1'b0, ovf_chk: 1'b0, illegal: 1'b0};
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_AND:  dec.ctrl = ALU_AND;
                    FN_OR:   dec.ctrl = ALU_OR;
                    FN_ADD:  begin dec.ctrl = ALU_ADD; dec.ovf_chk = 1'b1; end
                    FN_SLT:  dec.ctrl = ALU_SLT;
                    FN_ADDU: dec.ctrl = ALU_ADDU;
                    FN_SLL:  begin dec.ctrl = ALU_SLL; dec.swap_sll = 1'b1; end
                    FN_SUB:  begin dec.ctrl = ALU_SUB; dec.ovf_chk = 1'b1; end
                    FN_SUBU: dec.ctrl = ALU_SUB;   // same ALU op, overflow ignored
                    FN_SLTU: dec.ctrl = ALU_SLTU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin dec.ctrl = ALU_ADD;  dec.ext_sel = EXT_SIGN; dec.ovf_chk = 1'b1; end
            OP_ADDIU: begin dec.ctrl = ALU_ADDU; dec.ext_sel = EXT_SIGN; end
            OP_SLTI:  begin dec.ctrl = ALU_SLT;  dec.ext_sel = EXT_SIGN; end
            OP_SLTIU: begin dec.ctrl = ALU_SLTU; dec.ext_sel = EXT_SIGN; end
            OP_ANDI:  begin dec.ctrl = ALU_AND;  dec.ext_sel = EXT_ZERO; end
            OP_ORI:   begin dec.ctrl = ALU_OR;   dec.ext_sel = EXT_ZERO; end
            default:  dec.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_op_issue.sv
// Issue-side partner of the external 32-bit ALU.
//   Stage 1 registers the decoded ctrl and selected operands and drives the
//   ALU from them; stage 2 captures R and flags for writeback.
//   clk, reset : rising-edge clock, async active-high reset
//   bus        : alu_op_issue_if.slave (upstream, ALU and downstream buses)
// Build option: ALU_OVF_TRAP_EN turns signed overflow on ADD/SUB/ADDI into
// out_trap with the register write suppressed.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    alu_op_issue_if.slave bus
);
    dec_t          dec;
    logic          s1_v, s2_v, adv2, accept;
    logic [W-1:0]  imm_ext, a_nxt, b_nxt;
    logic [4:0]    sh_nxt;

    logic [2:0]    s1_ctrl;
    logic [W-1:0]  s1_a, s1_b;
    logic [4:0]    s1_shamt;
    logic [RW-1:0] s1_dst;
    logic          s1_ovf_chk, s1_illegal;
    logic          cout_en, trap_hit;

    logic [W-1:0]  o_r;
    logic [RW-1:0] o_dst;
    logic          o_wen, o_ze, o_cout, o_illegal, o_trap;

    alu_op_decode u_dec (
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .dec    (dec)
    );

    assign adv2         = !s2_v || bus.out_ready;
    assign bus.in_ready = !s1_v || adv2;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        imm_ext = (dec.ext_sel == EXT_SIGN) ? {{(W-16){bus.imm[15]}}, bus.imm}
                                            : {{(W-16){1'b0}}, bus.imm};
        a_nxt   = dec.swap_sll ? bus.rt_val : bus.rs_val;
        b_nxt   = (dec.ext_sel != EXT_NONE) ? imm_ext : bus.rt_val;
        sh_nxt  = dec.swap_sll ? bus.shamt_in : 5'd0;
        // Illegal ops still flow through, but with a benign AND of zeros.
        if (dec.illegal) begin
            a_nxt  = '0;
            b_nxt  = '0;
            sh_nxt = '0;
        end
    end

    // Carry is only meaningful for the adder-based ops.
    assign cout_en = (s1_ctrl == ALU_ADD) || (s1_ctrl == ALU_ADDU) || (s1_ctrl == ALU_SUB);

`ifdef ALU_OVF_TRAP_EN
    assign trap_hit = s1_ovf_chk && bus.alu_ovf;
`else
    logic unused_ovf;
    assign unused_ovf = s1_ovf_chk ^ bus.alu_ovf;
    assign trap_hit   = 1'b0;
`endif

    // Stage 1: holds its op (and so the ALU inputs) whenever it cannot advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v       <= 1'b0;
            s1_ctrl    <= ALU_AND;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_shamt   <= '0;
            s1_dst     <= '0;
            s1_ovf_chk <= 1'b0;
            s1_illegal <= 1'b0;
        end else begin
            if (bus.in_ready) s1_v <= bus.in_valid;
            if (accept) begin
                s1_ctrl    <= dec.ctrl;
                s1_a       <= a_nxt;
                s1_b       <= b_nxt;
                s1_shamt   <= sh_nxt;
                s1_dst     <= bus.dst;
                s1_ovf_chk <= dec.ovf_chk;
                s1_illegal <= dec.illegal;
            end
        end
    end

    // Stage 2: captures the ALU result; outputs hold while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_v      <= 1'b0;
            o_r       <= '0;
            o_dst     <= '0;
            o_wen     <= 1'b0;
            o_ze      <= 1'b0;
            o_cout    <= 1'b0;
            o_illegal <= 1'b0;
            o_trap    <= 1'b0;
        end else if (adv2) begin
            s2_v <= s1_v;
            if (s1_v) begin
                o_r       <= bus.alu_r;
                o_dst     <= s1_dst;
                o_wen     <= !s1_illegal && !trap_hit;
                o_ze      <= bus.alu_ze;
                o_cout    <= cout_en && bus.alu_cout;
                o_illegal <= s1_illegal;
                o_trap    <= trap_hit;
            end
        end
    end

    assign bus.alu_ctrl    = s1_ctrl;
    assign bus.alu_a       = s1_a;
    assign bus.alu_b       = s1_b;
    assign bus.alu_shamt   = s1_shamt;

    assign bus.out_valid   = s2_v;
    assign bus.out_r       = o_r;
    assign bus.out_dst     = o_dst;
    assign bus.out_wen     = o_wen;
    assign bus.out_ze      = o_ze;
    assign bus.out_cout    = o_cout;
    assign bus.out_illegal = o_illegal;
    assign bus.out_trap    = o_trap;
endmodule
